// File: rtl/hazard_detection_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use and branch-operand
// interlocks, a two-bubble branch-after-load sequence, and a saturating stall counter.
module hazard_detection_unit #(
  parameter int unsigned STALL_CNT_WIDTH = 16,
  parameter bit          BRANCH_IN_ID    = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_ID_EX_MemRead,
  input  logic                       in_ID_EX_RegWrite,
  input  logic [4:0]                 in_ID_EX_Rd_address_5,
  input  logic [4:0]                 in_IF_ID_Rs_address_5,
  input  logic [4:0]                 in_IF_ID_Rt_address_5,
  input  logic                       in_ID_uses_Rt,
  input  logic                       in_ID_branch,
  input  logic                       in_branch_taken,
  input  logic                       in_jump,
  output logic                       o_PC_write,
  output logic                       o_IF_ID_write,
  output logic                       o_ID_EX_bubble,
  output logic                       o_IF_ID_flush,
  output logic [STALL_CNT_WIDTH-1:0] o_stall_count
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HOLD = 1'b1
  } state_e;

  localparam logic [STALL_CNT_WIDTH-1:0] CNT_ONE = STALL_CNT_WIDTH'(1);

  state_e                     state_q, state_d;
  logic [STALL_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  logic match;
  logic load_use;
  logic br_alu;
  logic br_load;
  logic stall;
  logic flush;

  always_comb begin
    match = (in_ID_EX_Rd_address_5 != 5'd0) &&
            ((in_ID_EX_Rd_address_5 == in_IF_ID_Rs_address_5) ||
             (in_ID_uses_Rt && (in_ID_EX_Rd_address_5 == in_IF_ID_Rt_address_5)));

    load_use = in_ID_EX_MemRead && match;
    br_alu   = BRANCH_IN_ID && in_ID_branch && in_ID_EX_RegWrite &&
               !in_ID_EX_MemRead && match;
    br_load  = BRANCH_IN_ID && in_ID_branch && in_ID_EX_MemRead && match;

    // Outputs are gated by reset so they show reset values while it is held,
    // independent of whatever is sitting on the hazard inputs.
    stall = !reset && ((state_q == S_HOLD) ||
                       ((state_q == S_RUN) && (load_use || br_alu || br_load)));
    flush = !reset && !stall && (in_jump || (in_ID_branch && in_branch_taken));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (br_load) state_d = S_HOLD;
      S_HOLD:  state_d = S_RUN;
      default: state_d = S_RUN;
    endcase

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    o_PC_write     = !stall;
    o_IF_ID_write  = !stall;
    o_ID_EX_bubble = stall;
    o_IF_ID_flush  = flush;
    o_stall_count  = stall_cnt_q;
  end

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Self-checking bench: instance A (branches in ID, 16-bit counter) and instance B
// (branch checks off, 3-bit counter) are compared against a rule-level model.
module tb_hazard_detection_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       memread, regwrite, uses_rt, branch, taken, jump;
  logic [4:0] rd, rs, rt;

  logic        a_pc, a_ifid, a_bub, a_fl;
  logic [15:0] a_cnt;
  logic        b_pc, b_ifid, b_bub, b_fl;
  logic [2:0]  b_cnt;

  int n_checks = 0;
  int n_fails  = 0;
  bit m_hold_a, m_hold_b;
  int m_cnt_a, m_cnt_b;

  always #5 clk = ~clk;

  hazard_detection_unit #(.STALL_CNT_WIDTH(16), .BRANCH_IN_ID(1'b1)) dut_a (
    .clk(clk), .reset(rst),
    .in_ID_EX_MemRead(memread), .in_ID_EX_RegWrite(regwrite),
    .in_ID_EX_Rd_address_5(rd), .in_IF_ID_Rs_address_5(rs),
    .in_IF_ID_Rt_address_5(rt), .in_ID_uses_Rt(uses_rt),
    .in_ID_branch(branch), .in_branch_taken(taken), .in_jump(jump),
    .o_PC_write(a_pc), .o_IF_ID_write(a_ifid), .o_ID_EX_bubble(a_bub),
    .o_IF_ID_flush(a_fl), .o_stall_count(a_cnt)
  );

  hazard_detection_unit #(.STALL_CNT_WIDTH(3), .BRANCH_IN_ID(1'b0)) dut_b (
    .clk(clk), .reset(rst),
    .in_ID_EX_MemRead(memread), .in_ID_EX_RegWrite(regwrite),
    .in_ID_EX_Rd_address_5(rd), .in_IF_ID_Rs_address_5(rs),
    .in_IF_ID_Rt_address_5(rt), .in_ID_uses_Rt(uses_rt),
    .in_ID_branch(branch), .in_branch_taken(taken), .in_jump(jump),
    .o_PC_write(b_pc), .o_IF_ID_write(b_ifid), .o_ID_EX_bubble(b_bub),
    .o_IF_ID_flush(b_fl), .o_stall_count(b_cnt)
  );

  logic [3:0] outs_a, outs_b;
  assign outs_a = {a_pc, a_ifid, a_bub, a_fl};
  assign outs_b = {b_pc, b_ifid, b_bub, b_fl};

  // Returns {stall, enter_second_bubble} for the current inputs.
  function automatic logic [1:0] model_eval(bit br_en, bit hold);
    bit m, lu, ba, bl, st;
    m  = (rd != 0) && ((rd == rs) || (uses_rt && (rd == rt)));
    lu = memread && m;
    ba = br_en && branch && regwrite && !memread && m;
    bl = br_en && branch && memread && m;
    st = !rst && (hold || lu || ba || bl);
    return {st, !rst && !hold && bl};
  endfunction

  // Expected {PC_write, IF_ID_write, bubble, flush}.
  function automatic logic [3:0] exp_outs(bit br_en, bit hold);
    logic [1:0] e;
    bit fl;
    e  = model_eval(br_en, hold);
    fl = !rst && !e[1] && (jump || (branch && taken));
    return {!e[1], !e[1], e[1], fl};
  endfunction

  task automatic drive(input logic mr, input logic rw, input logic [4:0] d,
                       input logic [4:0] s, input logic [4:0] t, input logic ut,
                       input logic br, input logic tk, input logic j);
    memread = mr; regwrite = rw; rd = d; rs = s; rt = t;
    uses_rt = ut; branch = br; taken = tk; jump = j;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
  endtask

  // Advance one clock and update the model with the pre-edge decisions.
  task automatic tick();
    logic [1:0] ea, eb;
    ea = model_eval(1'b1, m_hold_a);
    eb = model_eval(1'b0, m_hold_b);
    @(posedge clk);
    if (!rst) begin
      m_hold_a = ea[0];
      m_hold_b = eb[0];
      if (ea[1] && m_cnt_a < 65535) m_cnt_a++;
      if (eb[1] && m_cnt_b < 7) m_cnt_b++;
    end
    @(negedge clk);
  endtask

  task automatic reset_all();
    rst = 1'b1;
    idle();
    m_hold_a = 0; m_hold_b = 0; m_cnt_a = 0; m_cnt_b = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    m_hold_a = 0; m_hold_b = 0; m_cnt_a = 0; m_cnt_b = 0;
    @(negedge clk);
    n_checks++;
    if ({outs_a, outs_b} !== 8'b1100_1100) begin
      n_fails++; $display("FAIL reset_outs: got %b_%b expected 1100_1100", outs_a, outs_b);
    end
    n_checks++;
    if (a_cnt !== 16'd0 || b_cnt !== 3'd0) begin
      n_fails++; $display("FAIL reset_count: got %0d/%0d expected 0/0", a_cnt, b_cnt);
    end
    rst = 1'b0;
    #1;
  endtask

  task automatic test_load_use();
    reset_all();
    drive(1, 1, 5'd8, 5'd8, 5'd11, 1, 0, 0, 0);   // lw $8 ; add $10,$8,$11
    n_checks++;
    if (outs_a !== 4'b0010 || outs_b !== 4'b0010) begin
      n_fails++; $display("FAIL load_use_stall: got %b/%b expected 0010/0010", outs_a, outs_b);
    end
    tick();
    idle();
    n_checks++;
    if (outs_a !== 4'b1100 || outs_b !== 4'b1100) begin
      n_fails++; $display("FAIL load_use_release: got %b/%b expected 1100/1100", outs_a, outs_b);
    end
    n_checks++;
    if (a_cnt !== 16'd1 || b_cnt !== 3'd1) begin
      n_fails++; $display("FAIL load_use_count: got %0d/%0d expected 1/1", a_cnt, b_cnt);
    end
  endtask

  task automatic test_branch_load();
    logic [3:0] want_a [3];
    logic [3:0] want_b [3];
    want_a = '{4'b0010, 4'b0010, 4'b1101};
    want_b = '{4'b0010, 4'b1101, 4'b1101};
    reset_all();
    for (int c = 0; c < 3; c++) begin
      if (c == 0) drive(1, 1, 5'd8, 5'd8, 5'd3, 1, 1, 1, 0);   // lw $8 ; beq $8,$3
      else        drive(0, 0, 5'd0, 5'd8, 5'd3, 1, 1, 1, 0);   // bubble in EX
      n_checks++;
      if (outs_a !== want_a[c] || outs_b !== want_b[c]) begin
        n_fails++;
        $display("FAIL branch_load_cyc%0d: got %b/%b expected %b/%b",
                 c, outs_a, outs_b, want_a[c], want_b[c]);
      end
      tick();
    end
    n_checks++;
    if (a_cnt !== 16'd2 || b_cnt !== 3'd1) begin
      n_fails++; $display("FAIL branch_load_count: got %0d/%0d expected 2/1", a_cnt, b_cnt);
    end
  endtask

  task automatic test_branch_alu();
    reset_all();
    drive(0, 1, 5'd5, 5'd0, 5'd5, 1, 1, 0, 0);   // add $5 ; bne $0,$5
    n_checks++;
    if (outs_a !== 4'b0010 || outs_b !== 4'b1100) begin
      n_fails++; $display("FAIL branch_alu: got %b/%b expected 0010/1100", outs_a, outs_b);
    end
    tick();
    drive(0, 0, 5'd0, 5'd0, 5'd5, 1, 1, 0, 0);
    n_checks++;
    if (outs_a !== 4'b1100 || a_cnt !== 16'd1) begin
      n_fails++; $display("FAIL branch_alu_release: got %b cnt %0d expected 1100 cnt 1", outs_a, a_cnt);
    end
  endtask

  task automatic test_no_hazard();
    reset_all();
    drive(1, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0);   // lw $0 ; reads $0
    n_checks++;
    if (outs_a !== 4'b1100 || outs_b !== 4'b1100) begin
      n_fails++; $display("FAIL rd_zero: got %b/%b expected 1100/1100", outs_a, outs_b);
    end
    tick();
    drive(1, 1, 5'd7, 5'd2, 5'd7, 0, 0, 0, 0);   // lw $7 ; addi with Rt=7 unused
    n_checks++;
    if (outs_a !== 4'b1100 || outs_b !== 4'b1100) begin
      n_fails++; $display("FAIL rt_unused: got %b/%b expected 1100/1100", outs_a, outs_b);
    end
    tick();
    n_checks++;
    if (a_cnt !== 16'd0 || b_cnt !== 3'd0) begin
      n_fails++; $display("FAIL no_hazard_count: got %0d/%0d expected 0/0", a_cnt, b_cnt);
    end
  endtask

  task automatic test_jump_flush();
    reset_all();
    drive(0, 0, 5'd0, 5'd4, 5'd5, 0, 0, 0, 1);
    n_checks++;
    if (outs_a !== 4'b1101 || outs_b !== 4'b1101) begin
      n_fails++; $display("FAIL jump_flush: got %b/%b expected 1101/1101", outs_a, outs_b);
    end
    tick();
    drive(1, 1, 5'd4, 5'd4, 5'd5, 0, 0, 0, 1);   // jr $4 behind lw $4
    n_checks++;
    if (outs_a !== 4'b0010 || outs_b !== 4'b0010) begin
      n_fails++; $display("FAIL jump_vs_stall: got %b/%b expected 0010/0010", outs_a, outs_b);
    end
    tick();
    drive(0, 0, 5'd0, 5'd4, 5'd5, 0, 0, 0, 1);
    n_checks++;
    if (outs_a !== 4'b1101) begin
      n_fails++; $display("FAIL jump_after_stall: got %b expected 1101", outs_a);
    end
    tick();
  endtask

  task automatic test_reset_mid_hold();
    reset_all();
    drive(1, 1, 5'd9, 5'd9, 5'd1, 1, 1, 0, 0);
    tick();
    idle();
    n_checks++;
    if (outs_a !== 4'b0010) begin
      n_fails++; $display("FAIL hold_stall: got %b expected 0010", outs_a);
    end
    rst = 1'b1;
    #1;
    m_hold_a = 0; m_hold_b = 0; m_cnt_a = 0; m_cnt_b = 0;
    n_checks++;
    if (outs_a !== 4'b1100 || a_cnt !== 16'd0) begin
      n_fails++; $display("FAIL reset_in_hold: got %b cnt %0d expected 1100 cnt 0", outs_a, a_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (outs_a !== 4'b1100) begin
      n_fails++; $display("FAIL hold_discarded: got %b expected 1100", outs_a);
    end
    tick();
  endtask

  task automatic test_saturation();
    reset_all();
    drive(1, 1, 5'd6, 5'd6, 5'd0, 0, 0, 0, 0);
    for (int c = 0; c < 10; c++) begin
      n_checks++;
      if (outs_b !== 4'b0010 || b_cnt !== 3'(m_cnt_b)) begin
        n_fails++; $display("FAIL sat_cyc%0d: got %b cnt %0d expected 0010 cnt %0d",
                            c, outs_b, b_cnt, m_cnt_b);
      end
      tick();
    end
    n_checks++;
    if (b_cnt !== 3'd7 || a_cnt !== 16'd10) begin
      n_fails++; $display("FAIL sat_final: got %0d/%0d expected 7/10", b_cnt, a_cnt);
    end
  endtask

  task automatic test_random();
    reset_all();
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0));
      n_checks++;
      if (outs_a !== exp_outs(1'b1, m_hold_a) || outs_b !== exp_outs(1'b0, m_hold_b)) begin
        n_fails++;
        $display("FAIL random_outs_cyc%0d: got %b/%b expected %b/%b", c, outs_a, outs_b,
                 exp_outs(1'b1, m_hold_a), exp_outs(1'b0, m_hold_b));
      end
      n_checks++;
      if (a_cnt !== 16'(m_cnt_a) || b_cnt !== 3'(m_cnt_b)) begin
        n_fails++;
        $display("FAIL random_count_cyc%0d: got %0d/%0d expected %0d/%0d",
                 c, a_cnt, b_cnt, m_cnt_a, m_cnt_b);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_load();
    test_branch_alu();
    test_no_hazard();
    test_jump_flush();
    test_reset_mid_hold();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/hazard_detection_unit.md
Name: hazard_detection_unit

Overview:
- Stall/flush controller for the 5-stage MIPS pipeline; the counterpart to the forwarding unit. It handles the hazards that bypass muxes cannot resolve.
- Sits in ID and watches the IF/ID and ID/EX pipeline registers. Drives PC write-enable, IF/ID write-enable, the ID/EX control-bubble mux and the IF/ID flush.
- A small FSM covers the two-bubble branch-after-load case. A saturating counter records total stall cycles for performance checks.

Parameters:
- STALL_CNT_WIDTH, 16, width of the stall-cycle counter o_stall_count.
- BRANCH_IN_ID, 1, 1 = branches compare in ID, so branch operand hazards are checked; 0 = branch checks disabled (load-use only).

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_ID_EX_MemRead  input  1  instruction in EX is a load
- in_ID_EX_RegWrite  input  1  instruction in EX writes a register
- in_ID_EX_Rd_address_5  input  5  destination register of the EX instruction, after the RegDst mux
- in_IF_ID_Rs_address_5  input  5  Rs field of the instruction in ID
- in_IF_ID_Rt_address_5  input  5  Rt field of the instruction in ID
- in_ID_uses_Rt  input  1  ID instruction reads Rt as a source (R-type, beq/bne, sw)
- in_ID_branch  input  1  ID instruction is beq/bne
- in_branch_taken  input  1  ID branch comparison resolved taken
- in_jump  input  1  ID instruction is j/jal/jr
- o_PC_write  output  1  PC write-enable
- o_IF_ID_write  output  1  IF/ID register write-enable
- o_ID_EX_bubble  output  1  zero all control signals entering ID/EX
- o_IF_ID_flush  output  1  clear IF/ID to nop on next edge
- o_stall_count  output  STALL_CNT_WIDTH  saturating count of stalled cycles

Behaviour:
- Reset: asynchronous, active-high. State = S_RUN; o_stall_count = 0; o_PC_write = 1, o_IF_ID_write = 1, o_ID_EX_bubble = 0, o_IF_ID_flush = 0.
- Match definition: match = (D != 0) & (D == Rs | (in_ID_uses_Rt & D == Rt)), where D = in_ID_EX_Rd_address_5. A destination of $0 never causes a hazard.
- Hazard terms:
  - load_use = in_ID_EX_MemRead & match.
  - br_alu = BRANCH_IN_ID & in_ID_branch & in_ID_EX_RegWrite & !in_ID_EX_MemRead & match.
  - br_load = BRANCH_IN_ID & in_ID_branch & in_ID_EX_MemRead & match.
- stall (Mealy, same cycle) = (S_RUN & (load_use | br_alu | br_load)) | S_HOLD.
  - When stall = 1: o_PC_write = 0, o_IF_ID_write = 0, o_ID_EX_bubble = 1.
  - When stall = 0: o_PC_write = 1, o_IF_ID_write = 1, o_ID_EX_bubble = 0.
- FSM: two states, S_RUN and S_HOLD.
  - S_RUN, br_load = 1: next state S_HOLD. Gives 2 bubbles total, because the load result is needed in ID (compare), not in EX.
  - S_RUN, load_use or br_alu (without br_load): 1 bubble; stay in S_RUN. On the next cycle ID/EX holds the bubble, so the condition clears naturally.
  - S_HOLD: stall unconditionally for exactly one cycle and ignore all hazard inputs; next state S_RUN.
- Flush: o_IF_ID_flush = !stall & (in_jump | (in_ID_branch & in_branch_taken)). Branch outcome is only trusted when its operands are valid, so stall has priority and flush is suppressed whenever stall = 1. Flush is a 1-cycle pulse per resolved control transfer; PC write stays 1 so the target is loaded.
- Counter: o_stall_count increments by 1 on each rising edge where stall = 1. It saturates at all-ones and never wraps. It is cleared only by reset.
- Reset mid-stall: returns to S_RUN immediately (asynchronous); outputs take their reset values; a pending second bubble is discarded.
- Simultaneous events: load_use and br_load both true resolves as br_load (2 bubbles). in_jump with a hazard in the same cycle gives stall and no flush; the jump re-evaluates after the stall.

Test Plan:
1. `lw $8,0($9)` in EX (MemRead = 1, Rd = 8), `add $10,$8,$11` in ID (Rs = 8) -> stall 1 cycle: PC_write = 0, IF_ID_write = 0, bubble = 1. Then release; state stays S_RUN; o_stall_count 0 -> 1.
2. `lw` to $8 in EX, `beq $8,$3` in ID (branch = 1, uses_Rt = 1) -> stall 2 consecutive cycles (S_RUN -> S_HOLD -> S_RUN); o_stall_count = 2; no flush during stall; flush = 1 on the 3rd cycle if branch_taken = 1.
3. `add` to $5 in EX (RegWrite = 1), `bne $0,$5` in ID -> exactly 1 bubble. With BRANCH_IN_ID = 0 -> 0 bubbles.
4. `lw` to $0 in EX, ID reads $0 -> no stall. `lw` to $7 with ID `addi` reading Rt = 7 but uses_Rt = 0 -> no stall.
5. No hazard, in_jump = 1 -> o_IF_ID_flush = 1 for one cycle, PC_write = 1. jump = 1 together with load_use -> flush = 0, stall = 1.
6. Assert reset while in S_HOLD -> all outputs return to reset values immediately and count = 0. Separately, preload the counter to all-ones (force) and stall -> value remains all-ones.
